bus_seq: RTL
============

Name: bus_seq

Overview:
- Bus access sequencer for the simplecore I/O bus, directly upstream of the tristate bus controller.
- Accepts single read/write requests from the core and drives address and chip/output/write strobes.
- Drives the direction control nRW and the outbound data word, then captures the inbound data word on reads.
- Enforces programmable wait states and a write-to-read bus turnaround so the shared data bus is never contended.

Parameters:
- AW, 16, address width
- DW, 16, data width
- WAIT_STATES, 2, strobe-active cycles per access; legal range 1..15 (0 is illegal)
- TURNAROUND, 1, idle cycles with nRW=0 after a write before the next access; legal range 0..3

Ports:
- clk  input  1  single system clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  1  access request, sampled only in IDLE
- wr  input  1  1 = write, 0 = read; sampled with req
- addr  input  AW  access address, sampled with req
- wdata  input  DW  write data, sampled with req
- busy  output  1  high from the cycle after acceptance until return to IDLE
- ack  output  1  one-cycle completion pulse; rdata is valid in this cycle on reads
- rdata  output  DW  captured read data, held until the next read completes
- bus_addr  output  AW  bus address
- nRW  output  1  1 = drive data bus (write); 0 = release bus (read/idle)
- dataOut  output  DW  outbound data word to the bus controller
- dataIn  input  DW  inbound data word from the bus controller
- nCS  output  1  chip select, active low
- nOE  output  1  output enable, active low, reads only
- nWE  output  1  write enable, active low, writes only

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high. Ports are named clk and rst.
- Outputs: all outputs are registered.
- Reset values: state=IDLE, busy=0, ack=0, rdata=0, bus_addr=0, dataOut=0, nRW=0, nCS=1, nOE=1, nWE=1.
- Reset mid-access: asserting rst drops nRW to 0 and deasserts all strobes immediately (asynchronously). No ack is issued for the aborted access.

State machine:
- IDLE: busy=0 and strobes are high.
  - If req=1, latch wr, addr and wdata, then go to SETUP.
- SETUP (1 cycle): nCS=0 and bus_addr=latched address.
  - Write: nRW=1 and dataOut=latched wdata.
  - Read: nRW=0.
  - nOE and nWE stay high. Load the wait counter with WAIT_STATES-1.
- STROBE (WAIT_STATES cycles): nOE=0 on reads, nWE=0 on writes. The counter decrements each cycle.
  - When the counter is 0, go to HOLD.
  - Read: dataIn is registered into rdata on this same exit edge.
- HOLD (1 cycle): nOE and nWE return high. nCS, bus_addr, nRW and dataOut are held, giving write hold time. ack=1 in this cycle.
  - Next state: TURN if write and TURNAROUND>0, otherwise IDLE.
- TURN (TURNAROUND cycles): nRW=0, nCS=1, busy=1. Then go to IDLE.
- Leaving HOLD or TURN: nCS=1 and nRW=0.

Latency (req sampled at edge 0):
- SETUP occupies cycle 1.
- STROBE occupies cycles 2..1+WAIT_STATES.
- ack is high in cycle 2+WAIT_STATES.
- Read access occupancy: 3+WAIT_STATES cycles.
- Write access occupancy: 3+WAIT_STATES+TURNAROUND cycles.

Handshake and boundary conditions:
- req is ignored while busy=1, including the ack cycle; the requester must hold req.
- If req is held continuously, the next access is accepted in the first IDLE cycle.
- Minimum gap between ack pulses is one IDLE cycle.
- nRW=1 only in SETUP, STROBE and HOLD of a write, so the data bus is driven only then.
- nOE=0 and nWE=0 are never asserted in the same cycle.
- nRW=1 and nOE=0 are never asserted in the same cycle.
- addr, wdata and wr may change freely after acceptance; the latched copies are used.
- rdata is unchanged by writes.

Test Plan:
- Reset: assert rst mid-STROBE of a write (WAIT_STATES=2) -> nRW=0, nWE=1, nCS=1 immediately; busy=0; no ack.
- Read: req=1, wr=0, addr=16'h0040, dataIn=16'hBEEF during STROBE, WAIT_STATES=2 -> nOE low for exactly 2 cycles; ack at cycle 4 after acceptance; rdata=16'hBEEF; nRW stays 0 throughout.
- Write: req=1, wr=1, addr=16'h0100, wdata=16'h1234, WAIT_STATES=2, TURNAROUND=1 -> nRW=1 with dataOut=16'h1234 in SETUP through HOLD; nWE low 2 cycles; ack at cycle 4; busy falls after TURN (cycle 6).
- Back-to-back: req held with a write to 16'h0002 then a read of 16'h0003 -> read SETUP begins only after the TURN cycle; nRW=1 never overlaps nOE=0; two ack pulses separated by at least one IDLE cycle.
- Busy-ignore: pulse req with wr=1, addr=16'hFFFF during a read's STROBE -> no extra access; exactly one ack; bus_addr unchanged.
- Wait-state sweep: WAIT_STATES=1 and 15 -> strobe width exactly 1 and 15 cycles; ack latency 3 and 17 cycles respectively.

Source files
------------

// File: rtl/bus_seq_if.sv
// Core-side request/ack signals plus the tristate bus controller side of one bus_seq.
// Not applicable: interface only, no logic and no latency.
// Not applicable: no flow control here; the core holds req until busy drops.
//   slave  : the sequencer's view (bus_seq)
//   master : the requester / bus controller view
interface bus_seq_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          req;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          busy;
    logic          ack;
    logic [DW-1:0] rdata;
    logic [AW-1:0] bus_addr;
    logic          nRW;
    logic [DW-1:0] dataOut;
    logic [DW-1:0] dataIn;
    logic          nCS;
    logic          nOE;
    logic          nWE;

    modport slave (
        input  req, wr, addr, wdata, dataIn,
        output busy, ack, rdata, bus_addr, nRW, dataOut, nCS, nOE, nWE
    );

    modport master (
        output req, wr, addr, wdata, dataIn,
        input  busy, ack, rdata, bus_addr, nRW, dataOut, nCS, nOE, nWE
    );
endinterface

// File: rtl/bus_seq.sv
// Sequences single read/write accesses onto the simplecore I/O bus, with wait states and write turnaround.
// Latency: req at edge 0 -> ack in cycle 2+WAIT_STATES. A read occupies 3+WAIT_STATES cycles; a write adds TURNAROUND.
// Backpressure: req is sampled only in IDLE, so the requester holds req until it is taken.
// Ports: clk, rst (async, active high); bif (slave modport) carries req/wr/addr/wdata/busy/ack/rdata
//        toward the core, and bus_addr/nRW/dataOut/dataIn/nCS/nOE/nWE toward the bus controller.
module bus_seq #(
    parameter int AW          = 16,
    parameter int DW          = 16,
    parameter int WAIT_STATES = 2,   // 1..15
    parameter int TURNAROUND  = 1    // 0..3
) (
    input  logic      clk,
    input  logic      rst,
    bus_seq_if.slave  bif
);
    localparam int CW = 4;

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, TURN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic          busy_q, busy_d;
    logic          ack_q, ack_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [AW-1:0] bus_addr_q, bus_addr_d;
    logic          nrw_q, nrw_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          ncs_q, ncs_d;
    logic          noe_q, noe_d;
    logic          nwe_q, nwe_d;

    // Every output is a flop, so the values below are the ones the bus sees
    // in the state being entered, not the state being left.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        busy_d     = busy_q;
        ack_d      = 1'b0;
        rdata_d    = rdata_q;
        bus_addr_d = bus_addr_q;
        nrw_d      = nrw_q;
        dout_d     = dout_q;
        ncs_d      = ncs_q;
        noe_d      = noe_q;
        nwe_d      = nwe_q;
        case (state_q)
            IDLE: begin
                if (bif.req) begin
                    state_d    = SETUP;
                    wr_d       = bif.wr;
                    bus_addr_d = bif.addr;
                    busy_d     = 1'b1;
                    ncs_d      = 1'b0;
                    // Direction is set a full cycle before any strobe moves.
                    nrw_d      = bif.wr;
                    if (bif.wr) begin
                        dout_d = bif.wdata;
                    end
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = CW'(WAIT_STATES - 1);
                noe_d   = wr_q;
                nwe_d   = ~wr_q;
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    noe_d   = 1'b1;
                    nwe_d   = 1'b1;
                    ack_d   = 1'b1;
                    if (!wr_q) begin
                        rdata_d = bif.dataIn;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            HOLD: begin
                ncs_d = 1'b1;
                nrw_d = 1'b0;
                if (wr_q && (TURNAROUND > 0)) begin
                    state_d = TURN;
                    cnt_d   = CW'(TURNAROUND - 1);
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            TURN: begin
                // Bus released but still busy: lets the write driver turn off
                // before a following read can enable the device's output.
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                ncs_d   = 1'b1;
                nrw_d   = 1'b0;
                noe_d   = 1'b1;
                nwe_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            rdata_q    <= '0;
            bus_addr_q <= '0;
            nrw_q      <= 1'b0;
            dout_q     <= '0;
            ncs_q      <= 1'b1;
            noe_q      <= 1'b1;
            nwe_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            bus_addr_q <= bus_addr_d;
            nrw_q      <= nrw_d;
            dout_q     <= dout_d;
            ncs_q      <= ncs_d;
            noe_q      <= noe_d;
            nwe_q      <= nwe_d;
        end
    end

    assign bif.busy     = busy_q;
    assign bif.ack      = ack_q;
    assign bif.rdata    = rdata_q;
    assign bif.bus_addr = bus_addr_q;
    assign bif.nRW      = nrw_q;
    assign bif.dataOut  = dout_q;
    assign bif.nCS      = ncs_q;
    assign bif.nOE      = noe_q;
    assign bif.nWE      = nwe_q;
endmodule
